serial_prod_accum: RTL and testbench
====================================

# serial_prod_accum

Downstream consumer of the bit-serial Booth multiplier. Accepts each serial product using the multiplier's valid/ready handshake, LSB first, 2*DATA_WIDTH bits per product. Deserialises the product and accumulates NUM_TERMS consecutive unsigned products into a parallel sum. Presents the sum on a parallel valid/ready port, which makes it the dot-product/MAC back end of the serial datapath.

## Interface
- DATA_WIDTH, 4, operand width of the upstream multiplier; serial product length is 2*DATA_WIDTH.
- NUM_TERMS, 4, products summed per result; must be >= 1.
- ACC_WIDTH, 2*DATA_WIDTH+2, accumulator/result width; must be >= 2*DATA_WIDTH.

Ports:
- i_clk  in  1  sole clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  global enable, shared with the upstream multiplier; low freezes all state.
- i_ser_din  in  1  serial product bit, LSB first.
- i_ser_valid  in  1  upstream has a product ready to shift.
- o_ser_ready  out  1  block accepts/is receiving a serial product.
- o_acc  out  ACC_WIDTH  accumulated result.
- o_acc_valid  out  1  o_acc holds a complete result.
- i_acc_ready  in  1  downstream accepts o_acc.
- o_ovf  out  1  accumulation overflowed ACC_WIDTH during the current result.

## Operation
- States: IDLE, SHIFT, ACCUM, OUT.
- o_ser_ready is combinational: 1 iff i_rst=0, i_en=1 and state is IDLE or SHIFT.
- IDLE: on an edge with i_en=1, i_ser_valid=1 and o_ser_ready=1 (the handshake edge), clear the bit counter and go to SHIFT.
- i_ser_valid is ignored outside IDLE.
- SHIFT: on each enabled edge, shift i_ser_din into the product register MSB-side (right shift) and increment the bit counter.
  - After the 2*DATA_WIDTH-th bit, go to ACCUM.
- ACCUM: for one cycle, add the zero-extended product to the accumulator and increment the term counter.
  - If the term count now equals NUM_TERMS, go to OUT; otherwise go to IDLE.
- OUT: o_acc_valid=1 and o_acc is stable.
  - On an edge with i_acc_ready=1 (and i_en=1), clear the accumulator, term counter and o_ovf, then go to IDLE.
  - o_ser_ready=0 in OUT, so upstream is back-pressured.
- Arithmetic:
  - Unsigned.
  - Sum width is ACC_WIDTH+1 internally.
  - The carry-out sets o_ovf (sticky until the result transfers).
  - The stored value follows the Configuration rule.
- i_en=0: no state, counter or register changes on that edge; handshake and result transfer are not taken.
- NUM_TERMS=1: every product goes IDLE→SHIFT→ACCUM→OUT.

## Timing
- Reset values: o_ser_ready=0 while i_rst=1, then 1 on the first cycle after reset with i_en=1. o_acc=0, o_acc_valid=0, o_ovf=0, state IDLE, all counters 0.
- Handshake at edge T0; bits sampled at edges T1..T2W (W=DATA_WIDTH); add at edge T2W+1.
  - o_ser_ready stays high from before T0 through T2W, and is low after T2W.
- When the last term's add happens at edge T2W+1, o_acc_valid is high from that edge on.
- Next product handshake can occur no earlier than edge T2W+2 (IDLE re-entered).
- Result transfer at edge Tx: o_acc_valid low after Tx; o_ser_ready high in the cycle after Tx.
- Reset mid-SHIFT, ACCUM or OUT: the partial product and accumulator are discarded. Block is in IDLE with reset values after the reset edge.
- Enable dropped mid-SHIFT: bit counter holds; capture resumes on the next enabled edge with no lost or duplicated bit.

## Configuration
- SERIAL_ACC_SATURATE_EN defined: on carry-out, the accumulator is clamped to 2^ACC_WIDTH-1. It stays clamped for the rest of the result, and o_ovf=1.
- Not defined: the accumulator wraps modulo 2^ACC_WIDTH; o_ovf=1 still reports the wrap.

## Test plan
- Defaults, products 15*15 ×4 (serial 8'hE1 each) → single result o_acc=900, o_ovf=0, o_acc_valid one edge after the 4th product's last bit.
- NUM_TERMS=1, product 0x0C (3*4) → o_acc=12 after 10 edges from handshake; i_acc_ready held low 5 cycles → o_acc stable, o_ser_ready=0 throughout, then transfer clears o_acc to 0.
- ACC_WIDTH=8, NUM_TERMS=2, products 225,225:
  - with SERIAL_ACC_SATURATE_EN → o_acc=255, o_ovf=1;
  - without → o_acc=194, o_ovf=1.
- i_en low for 3 cycles after bit 2 of product 0xA5 → captured product still 0xA5; counter resumes, total of 8 bits sampled.
- i_rst pulsed during SHIFT after 1 of 2 terms accumulated → o_acc=0, o_acc_valid=0, o_ser_ready=0 during reset. The next 2 products (6, 7) with NUM_TERMS=2 yield o_acc=13.
- Random 100 operand pairs fed through the multiplier+this block, NUM_TERMS=4 → each o_acc equals the sum of 4 reference products; zero mismatches.

Source files
------------

// File: rtl/serial_prod_accum.sv
// Serial product deserialiser and accumulator: sums NUM_TERMS unsigned LSB-first products.
// Build option: define SERIAL_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module serial_prod_accum #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned NUM_TERMS  = 4,
    parameter int unsigned ACC_WIDTH  = 2*DATA_WIDTH+2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_ser_din,
    input  logic                 i_ser_valid,
    output logic                 o_ser_ready,
    output logic [ACC_WIDTH-1:0] o_acc,
    output logic                 o_acc_valid,
    input  logic                 i_acc_ready,
    output logic                 o_ovf
);

    localparam int unsigned PROD_W = 2*DATA_WIDTH;
    localparam int unsigned BCNT_W = $clog2(PROD_W+1);
    localparam int unsigned TCNT_W = $clog2(NUM_TERMS+1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ACCUM, S_OUT} state_t;

    state_t                r_state;
    logic [PROD_W-1:0]     r_prod;
    logic [BCNT_W-1:0]     r_bcnt;
    logic [TCNT_W-1:0]     r_tcnt;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic                  r_acc_valid;
    logic                  r_ovf;

    logic [ACC_WIDTH:0]    w_sum;
    logic                  w_carry;
    logic [ACC_WIDTH-1:0]  w_acc_next;
    logic [TCNT_W-1:0]     w_tcnt_inc;
    logic                  w_last_bit;

    // One extra bit of sum width exposes the carry-out used for overflow.
    assign w_sum      = {1'b0, r_acc} + (ACC_WIDTH+1)'(r_prod);
    assign w_carry    = w_sum[ACC_WIDTH];
    assign w_tcnt_inc = TCNT_W'(r_tcnt + TCNT_W'(1));
    assign w_last_bit = (r_bcnt == BCNT_W'(PROD_W-1));

`ifdef SERIAL_ACC_SATURATE_EN
    // Once clamped, the result stays at full scale until it is transferred.
    assign w_acc_next = (w_carry || r_ovf) ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
`else
    assign w_acc_next = w_sum[ACC_WIDTH-1:0];
`endif

    assign o_ser_ready = !i_rst && i_en && ((r_state == S_IDLE) || (r_state == S_SHIFT));
    assign o_acc       = r_acc;
    assign o_acc_valid = r_acc_valid;
    assign o_ovf       = r_ovf;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_prod      <= '0;
            r_bcnt      <= '0;
            r_tcnt      <= '0;
            r_acc       <= '0;
            r_acc_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (i_en) begin
            case (r_state)
                S_IDLE: begin
                    if (i_ser_valid) begin
                        r_bcnt  <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // LSB arrives first, so shift right and insert at the MSB.
                    r_prod <= {i_ser_din, r_prod[PROD_W-1:1]};
                    r_bcnt <= BCNT_W'(r_bcnt + BCNT_W'(1));
                    if (w_last_bit) begin
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    r_acc  <= w_acc_next;
                    r_tcnt <= w_tcnt_inc;
                    if (w_carry) begin
                        r_ovf <= 1'b1;
                    end
                    if (w_tcnt_inc == TCNT_W'(NUM_TERMS)) begin
                        r_acc_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_OUT: begin
                    if (i_acc_ready) begin
                        r_acc       <= '0;
                        r_tcnt      <= '0;
                        r_ovf       <= 1'b0;
                        r_acc_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_prod_accum.sv
// Scoreboard bench for serial_prod_accum: two instances (4 terms/10-bit acc, 2 terms/8-bit acc).
module tb_serial_prod_accum;

    localparam int unsigned A_AW = 10;
    localparam int unsigned B_AW = 8;

    typedef struct {
        logic [9:0] acc;
        logic       ovf;
        int         hold;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst    [2] = '{1'b1, 1'b1};
    logic en     [2] = '{1'b1, 1'b1};
    logic din    [2] = '{1'b0, 1'b0};
    logic sval   [2] = '{1'b0, 1'b0};
    logic aready [2] = '{1'b0, 1'b0};
    logic busy   [2] = '{1'b0, 1'b0};

    logic [A_AW-1:0] acc_a;
    logic [B_AW-1:0] acc_b;
    logic sr_a, sr_b, v_a, v_b, o_a, o_b;

    logic       sready [2];
    logic       valid  [2];
    logic       ovf    [2];
    logic [9:0] acc    [2];

    assign sready[0] = sr_a;
    assign sready[1] = sr_b;
    assign valid[0]  = v_a;
    assign valid[1]  = v_b;
    assign ovf[0]    = o_a;
    assign ovf[1]    = o_b;
    assign acc[0]    = acc_a;
    assign acc[1]    = {2'b00, acc_b};

    serial_prod_accum #(.DATA_WIDTH(4), .NUM_TERMS(4), .ACC_WIDTH(A_AW)) u_a (
        .i_clk(clk), .i_rst(rst[0]), .i_en(en[0]), .i_ser_din(din[0]),
        .i_ser_valid(sval[0]), .o_ser_ready(sr_a), .o_acc(acc_a),
        .o_acc_valid(v_a), .i_acc_ready(aready[0]), .o_ovf(o_a)
    );

    serial_prod_accum #(.DATA_WIDTH(4), .NUM_TERMS(2), .ACC_WIDTH(B_AW)) u_b (
        .i_clk(clk), .i_rst(rst[1]), .i_en(en[1]), .i_ser_din(din[1]),
        .i_ser_valid(sval[1]), .o_ser_ready(sr_b), .o_acc(acc_b),
        .o_acc_valid(v_b), .i_acc_ready(aready[1]), .o_ovf(o_b)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t q0[$];
    exp_t q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic abort_run(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got timeout expected completion", name);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic push(input int d, input logic [9:0] a, input logic o, input int h);
        exp_t e;
        e.acc  = a;
        e.ovf  = o;
        e.hold = h;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Handshake, then drive the 8 product bits LSB first; optional enable gap after gap_at bits.
    task automatic send(input int d, input logic [7:0] p, input int gap_at, input int gap_len);
        int cnt;
        cnt = 0;
        @(posedge clk); #1 sval[d] = 1'b1;
        @(negedge clk);
        while (!sready[d]) begin
            cnt++;
            if (cnt > 400) abort_run($sformatf("handshake_timeout_inst%0d", d));
            @(negedge clk);
        end
        @(posedge clk); #1 sval[d] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == gap_at) begin
                en[d]  = 1'b0;
                din[d] = ~p[i];
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    if (g == 0) chk("en_low_ser_ready", 32'(sready[d]), 0);
                    @(posedge clk); #1;
                end
                en[d] = 1'b1;
            end
            din[d] = p[i];
            @(posedge clk); #1;
        end
    endtask

    task automatic monitor(input int d);
        exp_t       e;
        logic       have;
        logic [9:0] held;
        forever begin
            @(negedge clk);
            if (valid[d]) begin
                busy[d] = 1'b1;
                have    = 1'b0;
                if (d == 0 && q0.size() > 0) begin
                    e = q0.pop_front(); have = 1'b1;
                end else if (d == 1 && q1.size() > 0) begin
                    e = q1.pop_front(); have = 1'b1;
                end
                if (!have) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result_inst%0d: got %0d expected none", d, acc[d]);
                    e.hold = 0;
                end else begin
                    chk($sformatf("acc_inst%0d", d), 32'(acc[d]), 32'(e.acc));
                    chk($sformatf("ovf_inst%0d", d), 32'(ovf[d]), 32'(e.ovf));
                end
                held = acc[d];
                for (int k = 0; k < e.hold; k++) begin
                    @(negedge clk);
                    chk("hold_acc", 32'(acc[d]), 32'(held));
                    chk("hold_valid", 32'(valid[d]), 1);
                    chk("hold_ser_ready", 32'(sready[d]), 0);
                end
                @(posedge clk); #1 aready[d] = 1'b1;
                @(posedge clk); #1 aready[d] = 1'b0;
                @(negedge clk);
                chk("post_xfer_valid", 32'(valid[d]), 0);
                chk("post_xfer_acc", 32'(acc[d]), 0);
                chk("post_xfer_ovf", 32'(ovf[d]), 0);
                chk("post_xfer_ser_ready", 32'(sready[d]), 1);
                busy[d] = 1'b0;
            end
        end
    endtask

    initial begin
        int         prods [4];
        int         sum;
        int         cnt;
        logic [7:0] pb;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_acc", 32'(acc[d]), 0);
            chk("rst_valid", 32'(valid[d]), 0);
            chk("rst_ovf", 32'(ovf[d]), 0);
            chk("rst_ser_ready", 32'(sready[d]), 0);
        end
        @(posedge clk); #1 rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        chk("post_rst_ser_ready_a", 32'(sready[0]), 1);
        chk("post_rst_ser_ready_b", 32'(sready[1]), 1);

        fork
            monitor(0);
            monitor(1);
        join_none

        // Four 15*15 products; result valid exactly one edge after the last bit.
        push(0, 10'd900, 1'b0, 0);
        repeat (4) send(0, 8'hE1, -1, 0);
        @(negedge clk);
        chk("lat_valid_before_add", 32'(valid[0]), 0);
        chk("lat_ser_ready_accum", 32'(sready[0]), 0);
        @(negedge clk);
        chk("lat_valid_after_add", 32'(valid[0]), 1);

        // Enable gap inside 0xA5, then result held 5 cycles by downstream.
        push(0, 10'd171, 1'b0, 5);
        send(0, 8'hA5, 2, 3);
        send(0, 8'h01, -1, 0);
        send(0, 8'h02, -1, 0);
        send(0, 8'h03, -1, 0);

        // 100 random operand pairs, 25 results of 4 products each.
        for (int r = 0; r < 25; r++) begin
            sum = 0;
            for (int t = 0; t < 4; t++) begin
                prods[t] = $urandom_range(0, 15) * $urandom_range(0, 15);
                sum += prods[t];
            end
            push(0, 10'(sum), 1'b0, 0);
            for (int t = 0; t < 4; t++) begin
                pb = 8'(prods[t]);
                send(0, pb, -1, 0);
            end
        end

        // 225+225 overflows an 8-bit accumulator.
`ifdef SERIAL_ACC_SATURATE_EN
        push(1, 10'd255, 1'b1, 0);
`else
        push(1, 10'd194, 1'b1, 0);
`endif
        send(1, 8'd225, -1, 0);
        send(1, 8'd225, -1, 0);

        // One term accumulated, reset mid-SHIFT of the second: all discarded.
        send(1, 8'd50, -1, 0);
        repeat (2) @(posedge clk);
        #1 sval[1] = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (!sready[1]) begin
            cnt++;
            if (cnt > 400) abort_run("reset_test_handshake_timeout");
            @(negedge clk);
        end
        @(posedge clk); #1 sval[1] = 1'b0; din[1] = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst[1] = 1'b1;
        @(negedge clk);
        chk("rst_mid_ser_ready_comb", 32'(sready[1]), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_acc", 32'(acc[1]), 0);
        chk("rst_mid_valid", 32'(valid[1]), 0);
        chk("rst_mid_ser_ready", 32'(sready[1]), 0);
        @(posedge clk); #1 rst[1] = 1'b0;
        @(negedge clk);
        chk("rst_mid_release_ready", 32'(sready[1]), 1);
        push(1, 10'd13, 1'b0, 0);
        send(1, 8'd6, -1, 0);
        send(1, 8'd7, -1, 0);

        // Let the monitors drain every outstanding result.
        cnt = 0;
        repeat (2) @(negedge clk);
        while (q0.size() != 0 || q1.size() != 0 || busy[0] || busy[1]) begin
            cnt++;
            if (cnt > 500) abort_run("drain_timeout");
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("final_queue_a_empty", 32'(q0.size()), 0);
        chk("final_queue_b_empty", 32'(q1.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
